data_mem_unit: RTL and testbench

Data memory and memory-mapped I/O unit directly downstream of the pipeline CPU's MEM stage. It consumes the CPU's data-memory address, store data and write strobe, plus a load/store width code, and returns load data combinationally in the same cycle so the MEM/WB register can capture it. It also hosts a small MMIO window: an output register, a free-running cycle counter, and a sticky misalignment status.

---
 rtl/data_mem_unit.sv | 165 ++++++++++++++++
 tb/tb_data_mem_unit.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_unit.sv
// Data RAM plus a 16-byte MMIO window (io_out, cycle counter, misalign status) behind the MEM stage.
// Loads are combinational (0 cycles), stores commit at the next rising edge; always ready, no backpressure.
module data_mem_unit #(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_w,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [2:0]  dm_type,
   output logic [31:0] rdata,
   output logic [31:0] io_out,
   output logic        misalign,
   output logic [31:0] err_addr
);
   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} size_e;

   logic [31:0] mem [DEPTH_WORDS];

   logic [31:0] io_out_q, io_out_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] err_addr_q, err_addr_d;
   logic        misalign_q, misalign_d;
   logic        run_q, run_d;

   size_e         size;
   logic          sign_ext;
   logic          is_mmio;
   logic          mis;
   logic          ram_we;
   logic [AW-1:0] widx;
   logic [31:0]   ram_word;
   logic [31:0]   lane_wdata;
   logic [3:0]    be;
   logic [7:0]    rd_byte;
   logic [15:0]   rd_half;

   always_comb begin
      size     = SZ_WORD;
      sign_ext = 1'b0;
      case (dm_type)
         3'b001:  begin size = SZ_HALF; sign_ext = 1'b1; end
         3'b010:  size = SZ_HALF;
         3'b011:  begin size = SZ_BYTE; sign_ext = 1'b1; end
         3'b100:  size = SZ_BYTE;
         default: ;
      endcase
   end

   assign is_mmio  = (addr[31:4] == MMIO_BASE[31:4]);
   assign widx     = addr[AW+1:2];
   assign ram_word = mem[widx];

   // MMIO registers only accept whole, aligned words.
   always_comb begin
      mis = 1'b0;
      case (size)
         SZ_HALF: mis = addr[0];
         SZ_BYTE: mis = 1'b0;
         default: mis = (addr[1:0] != 2'b00);
      endcase
      if (is_mmio && size != SZ_WORD) mis = 1'b1;
   end

   always_comb begin
      rd_byte = ram_word[{addr[1:0], 3'b000} +: 8];
      rd_half = addr[1] ? ram_word[31:16] : ram_word[15:0];
      rdata   = 32'h0;
      if (mis) begin
         rdata = 32'h0;
      end else if (is_mmio) begin
         case (addr[3:2])
            2'd0:    rdata = io_out_q;
            2'd1:    rdata = cnt_q;
            2'd2:    rdata = {31'b0, misalign_q};
            default: rdata = 32'h0;
         endcase
      end else begin
         case (size)
            SZ_BYTE: rdata = {{24{sign_ext & rd_byte[7]}}, rd_byte};
            SZ_HALF: rdata = {{16{sign_ext & rd_half[15]}}, rd_half};
            default: rdata = ram_word;
         endcase
      end
   end

   // Narrow store data is replicated across lanes; byte enables pick the target lane.
   always_comb begin
      be         = 4'b0000;
      lane_wdata = wdata;
      case (size)
         SZ_BYTE: begin
            be         = 4'b0001 << addr[1:0];
            lane_wdata = {4{wdata[7:0]}};
         end
         SZ_HALF: begin
            be         = addr[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{wdata[15:0]}};
         end
         default: be = 4'b1111;
      endcase
   end

   assign ram_we = mem_w && !mis && !is_mmio;

   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[widx][8*i +: 8] <= lane_wdata[8*i +: 8];
         end
      end
   end

   // run_q keeps the counter at zero through the first edge after reset release.
   always_comb begin
      io_out_d   = io_out_q;
      cnt_d      = run_q ? cnt_q + 32'd1 : cnt_q;
      run_d      = 1'b1;
      misalign_d = misalign_q;
      err_addr_d = err_addr_q;
      if (mem_w) begin
         if (mis) begin
            misalign_d = 1'b1;
            if (!misalign_q) err_addr_d = addr;
         end else if (is_mmio) begin
            case (addr[3:2])
               2'd0: io_out_d = wdata;
               2'd1: cnt_d    = wdata;
               2'd2: begin
                  if (wdata[0]) begin
                     misalign_d = 1'b0;
                     err_addr_d = 32'h0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         io_out_q   <= 32'h0;
         cnt_q      <= 32'h0;
         err_addr_q <= 32'h0;
         misalign_q <= 1'b0;
         run_q      <= 1'b0;
      end else begin
         io_out_q   <= io_out_d;
         cnt_q      <= cnt_d;
         err_addr_q <= err_addr_d;
         misalign_q <= misalign_d;
         run_q      <= run_d;
      end
   end

   assign io_out   = io_out_q;
   assign misalign = misalign_q;
   assign err_addr = err_addr_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: directed scenarios plus random traffic against a byte-level reference model.
module tb_data_mem_unit;
   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'hFFFF_0000;
   localparam logic [2:0]  T_W   = 3'd0;
   localparam logic [2:0]  T_H   = 3'd1;
   localparam logic [2:0]  T_HU  = 3'd2;
   localparam logic [2:0]  T_B   = 3'd3;
   localparam logic [2:0]  T_BU  = 3'd4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_w = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic [2:0]  dm_type = 3'd0;
   logic [31:0] rdata;
   logic [31:0] io_out;
   logic        misalign;
   logic [31:0] err_addr;

   int n_total = 0;
   int n_bad   = 0;

   logic [7:0]  m_mem [DEPTH*4];
   logic [31:0] m_io, m_cnt, m_err;
   logic        m_mis, m_run;

   data_mem_unit #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(BASE)) dut (
      .clk      (clk),
      .reset    (reset),
      .mem_w    (mem_w),
      .addr     (addr),
      .wdata    (wdata),
      .dm_type  (dm_type),
      .rdata    (rdata),
      .io_out   (io_out),
      .misalign (misalign),
      .err_addr (err_addr)
   );

   always #5 clk = ~clk;

   function automatic int acc_size(input logic [2:0] t);
      if (t == T_H || t == T_HU) return 2;
      if (t == T_B || t == T_BU) return 1;
      return 4;
   endfunction

   function automatic logic is_mmio(input logic [31:0] a);
      return (a >> 4) == (BASE >> 4);
   endfunction

   function automatic logic model_mis(input logic [31:0] a, input logic [2:0] t);
      int sz;
      sz = acc_size(t);
      if (is_mmio(a)) return (sz != 4) || ((a % 32'd4) != 0);
      return (a % 32'(sz)) != 0;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a, input logic [2:0] t);
      logic [31:0] v;
      int unsigned base;
      int          sz;
      v = 32'h0;
      if (model_mis(a, t)) return 32'h0;
      if (is_mmio(a)) begin
         if ((a % 16) == 0) return m_io;
         if ((a % 16) == 4) return m_cnt;
         if ((a % 16) == 8) return {31'b0, m_mis};
         return 32'h0;
      end
      sz   = acc_size(t);
      base = a % (DEPTH * 4);
      for (int i = 0; i < sz; i++) v = v | (32'(m_mem[base + i]) << (8 * i));
      if (t == T_H && v[15]) v = v | 32'hFFFF_0000;
      if (t == T_B && v[7])  v = v | 32'hFFFF_FF00;
      return v;
   endfunction

   task automatic model_reset();
      m_io  = 32'h0;
      m_cnt = 32'h0;
      m_err = 32'h0;
      m_mis = 1'b0;
      m_run = 1'b0;
   endtask

   // Applies the effect of one rising edge with the currently driven inputs.
   task automatic model_edge();
      logic [31:0] nxt;
      int unsigned base;
      nxt   = m_run ? m_cnt + 32'd1 : m_cnt;
      m_run = 1'b1;
      if (mem_w) begin
         if (model_mis(addr, dm_type)) begin
            if (!m_mis) m_err = addr;
            m_mis = 1'b1;
         end else if (is_mmio(addr)) begin
            if ((addr % 16) == 0) m_io = wdata;
            if ((addr % 16) == 4) nxt = wdata;
            if ((addr % 16) == 8 && wdata[0]) begin
               m_mis = 1'b0;
               m_err = 32'h0;
            end
         end else begin
            base = addr % (DEPTH * 4);
            for (int i = 0; i < acc_size(dm_type); i++) m_mem[base + i] = 8'(wdata >> (8 * i));
         end
      end
      m_cnt = nxt;
   endtask

   task automatic drive(input logic mw, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] t);
      mem_w   = mw;
      addr    = a;
      wdata   = wd;
      dm_type = t;
      #1;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [31:0] exp_c [4];
      exp_c = '{32'd0, 32'd0, 32'd1, 32'd2};
      repeat (2) @(negedge clk);
      n_total++;
      if (io_out !== 32'h0 || misalign !== 1'b0 || err_addr !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_state got io=%h mis=%b err=%h exp io=0 mis=0 err=0", io_out, misalign, err_addr);
      end
      reset = 1'b0;
      model_reset();
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, BASE + 32'd4, 32'h0, T_W);
         n_total++;
         if (rdata !== exp_c[k]) begin
            n_bad++;
            $display("FAIL cnt_after_reset[%0d] got=%h exp=%h", k, rdata, exp_c[k]);
         end
         tick();
      end
   endtask

   task automatic test_word_access();
      logic [31:0] ta [5];
      logic [2:0]  tt [5];
      logic [31:0] te [5];
      ta = '{32'h100, 32'h101, 32'h103, 32'h102, 32'h100};
      tt = '{T_W, T_BU, T_B, T_HU, T_H};
      te = '{32'hDEAD_BEEF, 32'h0000_00BE, 32'hFFFF_FFDE, 32'h0000_DEAD, 32'hFFFF_BEEF};
      drive(1'b1, 32'h100, 32'hDEAD_BEEF, T_W);
      tick();
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, ta[k], 32'h0, tt[k]);
         n_total++;
         if (rdata !== te[k]) begin
            n_bad++;
            $display("FAIL load[%0d] addr=%h type=%0d got=%h exp=%h", k, ta[k], tt[k], rdata, te[k]);
         end
         tick();
      end
   endtask

   task automatic test_narrow_stores();
      drive(1'b1, 32'h101, 32'h0000_0012, T_B);
      n_total++;
      if (rdata !== 32'hFFFF_FFBE) begin
         n_bad++;
         $display("FAIL sb_prewrite got=%h exp=ffffffbe", rdata);
      end
      tick();
      drive(1'b1, 32'h102, 32'h0000_3456, T_H);
      n_total++;
      if (rdata !== 32'hFFFF_DEAD) begin
         n_bad++;
         $display("FAIL sh_prewrite got=%h exp=ffffdead", rdata);
      end
      tick();
      drive(1'b0, 32'h100, 32'h0, T_W);
      n_total++;
      if (rdata !== 32'h3456_12EF) begin
         n_bad++;
         $display("FAIL narrow_merge got=%h exp=345612ef", rdata);
      end
      tick();
   endtask

   task automatic test_misalign();
      drive(1'b1, 32'h102, 32'h1111_1111, T_W);
      n_total++;
      if (rdata !== 32'h0) begin
         n_bad++;
         $display("FAIL mis_rdata got=%h exp=0", rdata);
      end
      tick();
      n_total++;
      if (misalign !== 1'b1 || err_addr !== 32'h102) begin
         n_bad++;
         $display("FAIL mis_first got mis=%b err=%h exp mis=1 err=102", misalign, err_addr);
      end
      drive(1'b0, 32'h100, 32'h0, T_W);
      n_total++;
      if (rdata !== 32'h3456_12EF) begin
         n_bad++;
         $display("FAIL mis_suppressed got=%h exp=345612ef", rdata);
      end
      tick();
      drive(1'b1, 32'h105, 32'h0000_BEEF, T_H);
      tick();
      n_total++;
      if (misalign !== 1'b1 || err_addr !== 32'h102) begin
         n_bad++;
         $display("FAIL mis_sticky got mis=%b err=%h exp mis=1 err=102", misalign, err_addr);
      end
      drive(1'b1, BASE + 32'd8, 32'h1, T_W);
      n_total++;
      if (rdata !== 32'h1) begin
         n_bad++;
         $display("FAIL status_read got=%h exp=1", rdata);
      end
      tick();
      n_total++;
      if (misalign !== 1'b0 || err_addr !== 32'h0) begin
         n_bad++;
         $display("FAIL status_clear got mis=%b err=%h exp mis=0 err=0", misalign, err_addr);
      end
      drive(1'b0, 32'h101, 32'h0, T_W);
      n_total++;
      if (rdata !== 32'h0) begin
         n_bad++;
         $display("FAIL mis_load_rdata got=%h exp=0", rdata);
      end
      tick();
      n_total++;
      if (misalign !== 1'b0) begin
         n_bad++;
         $display("FAIL mis_load_noflag got=%b exp=0", misalign);
      end
   endtask

   task automatic test_mmio();
      drive(1'b1, BASE, 32'hA5A5_0001, T_W);
      n_total++;
      if (io_out !== 32'h0) begin
         n_bad++;
         $display("FAIL io_before_edge got=%h exp=0", io_out);
      end
      tick();
      n_total++;
      if (io_out !== 32'hA5A5_0001) begin
         n_bad++;
         $display("FAIL io_write got=%h exp=a5a50001", io_out);
      end
      drive(1'b0, BASE, 32'h0, T_W);
      n_total++;
      if (rdata !== 32'hA5A5_0001) begin
         n_bad++;
         $display("FAIL io_readback got=%h exp=a5a50001", rdata);
      end
      tick();
      drive(1'b1, BASE + 32'd12, 32'hFFFF_FFFF, T_W);
      n_total++;
      if (rdata !== 32'h0) begin
         n_bad++;
         $display("FAIL mmio_c_read got=%h exp=0", rdata);
      end
      tick();
      n_total++;
      if (misalign !== 1'b0 || io_out !== 32'hA5A5_0001) begin
         n_bad++;
         $display("FAIL mmio_c_write got mis=%b io=%h exp mis=0 io=a5a50001", misalign, io_out);
      end
      drive(1'b1, BASE, 32'h0000_00FF, T_B);
      tick();
      n_total++;
      if (misalign !== 1'b1 || err_addr !== BASE || io_out !== 32'hA5A5_0001) begin
         n_bad++;
         $display("FAIL mmio_sb got mis=%b err=%h io=%h exp mis=1 err=%h io=a5a50001",
                  misalign, err_addr, io_out, BASE);
      end
      drive(1'b1, BASE + 32'd8, 32'h1, T_W);
      tick();
   endtask

   task automatic test_counter();
      logic [31:0] exp_c [3];
      exp_c = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
      drive(1'b1, BASE + 32'd4, 32'hFFFF_FFFE, T_W);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, BASE + 32'd4, 32'h0, T_W);
         n_total++;
         if (rdata !== exp_c[k]) begin
            n_bad++;
            $display("FAIL cnt_wrap[%0d] got=%h exp=%h", k, rdata, exp_c[k]);
         end
         tick();
      end
   endtask

   task automatic test_async_reset();
      drive(1'b1, BASE, 32'h5, T_W);
      tick();
      drive(1'b1, BASE, 32'h0, T_BU);
      tick();
      n_total++;
      if (io_out !== 32'h5 || misalign !== 1'b1) begin
         n_bad++;
         $display("FAIL pre_reset got io=%h mis=%b exp io=5 mis=1", io_out, misalign);
      end
      drive(1'b0, BASE + 32'd4, 32'h0, T_W);
      #2;
      reset = 1'b1;
      #1;
      n_total++;
      if (io_out !== 32'h0 || misalign !== 1'b0 || err_addr !== 32'h0 || rdata !== 32'h0) begin
         n_bad++;
         $display("FAIL async_reset got io=%h mis=%b err=%h cnt=%h exp all 0", io_out, misalign, err_addr, rdata);
      end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      drive(1'b0, 32'h100, 32'h0, T_W);
      n_total++;
      if (rdata !== 32'h3456_12EF) begin
         n_bad++;
         $display("FAIL ram_survives_reset got=%h exp=345612ef", rdata);
      end
      tick();
   endtask

   task automatic test_random();
      logic [31:0] a, wd, exp;
      logic [2:0]  t;
      logic        mw;
      for (int w = 0; w < 16; w++) begin
         drive(1'b1, 32'(w * 4), $urandom, T_W);
         tick();
      end
      for (int it = 0; it < 300; it++) begin
         if ($urandom_range(0, 9) == 0) a = BASE + 32'($urandom_range(0, 15));
         else a = (32'($urandom_range(0, 1023)) << 12) | 32'($urandom_range(0, 63));
         wd = $urandom;
         t  = 3'($urandom_range(0, 7));
         mw = 1'($urandom_range(0, 1));
         drive(mw, a, wd, t);
         exp = model_read(a, t);
         n_total++;
         if (rdata !== exp) begin
            n_bad++;
            $display("FAIL rand_rdata it=%0d addr=%h type=%0d got=%h exp=%h", it, a, t, rdata, exp);
         end
         tick();
         n_total++;
         if (io_out !== m_io || misalign !== m_mis || err_addr !== m_err) begin
            n_bad++;
            $display("FAIL rand_state it=%0d got io=%h mis=%b err=%h exp io=%h mis=%b err=%h",
                     it, io_out, misalign, err_addr, m_io, m_mis, m_err);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_word_access();
      test_narrow_stores();
      test_misalign();
      test_mmio();
      test_counter();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
